dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
Single-port arbiter and sequencer for the data-memory block RAM. It shares one port between three requesters: CPU load/store, UART bootloader upload writes, and a debug readout port that drives the LED/seven-segment memory view. It sits between the MemOrIO/DMem boundary and the BRAM, issues one access at a time, returns read data after the BRAM's 1-cycle latency, and stalls the CPU while an upload is active.

Parameters:
ADDR_W, 14, word-address width (BRAM depth 2^ADDR_W words)
DATA_W, 32, data width
STARVE_LIMIT, 15, consecutive lost arbitrations after which a pending debug request wins

Ports:
clk  in  1  system clock (cpu_clk domain)
rst  in  1  asynchronous active-high reset
cpu_req  in  1  CPU access request, held until the access completes
cpu_we  in  1  1=store, 0=load
cpu_addr  in  ADDR_W  CPU word address
cpu_wdata  in  DATA_W  CPU store data
cpu_gnt  out  1  1-cycle pulse: CPU access issued
cpu_rvalid  out  1  1-cycle pulse: rdata valid for CPU load
cpu_stall  out  1  CPU must hold its pipeline
upg_done  in  1  0=upload in progress (exclusive mode), 1=normal
upg_req  in  1  upload write request
upg_addr  in  ADDR_W  upload word address
upg_wdata  in  DATA_W  upload write data
upg_gnt  out  1  1-cycle pulse: upload write issued
dbg_req  in  1  debug read request
dbg_addr  in  ADDR_W  debug word address
dbg_gnt  out  1  1-cycle pulse: debug read issued
dbg_rvalid  out  1  1-cycle pulse: rdata valid for debug
rdata  out  DATA_W  read data, shared by the CPU and debug ports
mem_en  out  1  BRAM enable
mem_we  out  1  BRAM write enable
mem_addr  out  ADDR_W  BRAM address
mem_wdata  out  DATA_W  BRAM write data
mem_rdata  in  DATA_W  BRAM read data, valid the cycle after mem_en with mem_we=0

Behaviour:
- Reset values: state IDLE, owner NONE. All gnt/rvalid pulses, mem_en and mem_we are 0. mem_addr, mem_wdata and rdata are 0. The starvation counter is 0.
- Reset mid-operation aborts the access; no gnt or rvalid follows.
- FSM has three states: IDLE, ISSUE, RDWAIT. Only one access is outstanding at a time.
- IDLE, arbitration rule:
  - If any eligible request is present in cycle N: latch owner/addr/we/wdata and go to ISSUE at N+1.
  - Eligible when upg_done=0: upg_req only. cpu_req and dbg_req are ignored.
  - Eligible when upg_done=1: cpu_req and dbg_req. upg_req is ignored.
  - Priority when upg_done=1: CPU over debug, unless starve_cnt==STARVE_LIMIT, in which case debug wins.
- ISSUE (N+1):
  - mem_en=1, mem_we=latched we; owner's gnt=1 for this one cycle.
  - Write: go to IDLE at N+2.
  - Read: go to RDWAIT at N+2.
- RDWAIT (N+2): rdata=mem_rdata, registered into rdata in the same cycle. Owner's rvalid=1, then IDLE at N+3.
- Latency and throughput:
  - Load: 3 cycles from request to rvalid.
  - Store: 2 cycles from request to gnt.
  - Back-to-back accesses run at most one per 2 cycles (writes) or one per 3 cycles (reads).
- Requester rules:
  - Requests are sampled only in IDLE.
  - A requester may drop or change its request in the cycle after gnt; stale req during ISSUE/RDWAIT is harmless.
  - Address and data are latched, so a requester may change them after gnt.
- Starvation counter:
  - Increments, saturating at STARVE_LIMIT, on each IDLE arbitration where dbg_req=1 and CPU wins.
  - Clears on dbg_gnt or when dbg_req=0.
- cpu_stall (combinational) = ~upg_done | (cpu_req & ~cpu_done), where cpu_done = cpu_gnt&cpu_we | cpu_rvalid.
- upg_done falling mid-access: the current access completes normally; the next arbitration is upload-only.
- upg_done rising: normal arbitration resumes in the next IDLE cycle.
- Address wrap-around is not handled: addresses are used modulo 2^ADDR_W.
- mem_addr and mem_wdata hold their last values when mem_en=0.

Optional Feature:
ARB_PERF_CNT_EN:
- Defined: adds ports perf_sel (in, 2) and perf_cnt (out, 32). perf_sel selects one of four counters:
  - 0 = CPU grants
  - 1 = upload grants
  - 2 = debug grants
  - 3 = cycles with cpu_stall=1
- All counters saturate at 0xFFFFFFFF and are cleared by rst.
- Not defined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package dmem_arb_pkg holds:
  - the state encoding (IDLE/ISSUE/RDWAIT)
  - the owner encoding (OWN_NONE/OWN_CPU/OWN_UPG/OWN_DBG)
  - the perf_sel codes
- One sub-module, dmem_arb_pick: combinational winner selection (upg_done mode, priority, starvation override), plus the starvation counter register.

Test Plan:
- CPU load: upg_done=1, cpu_req=1, we=0, addr=0x010, BRAM[0x010]=0xDEADBEEF -> cpu_gnt at N+1 with mem_en=1 and mem_addr=0x010; cpu_rvalid at N+2 with rdata=0xDEADBEEF; cpu_stall falls at N+2.
- Upload exclusivity: upg_done=0; cpu_req, dbg_req and upg_req all set, upg_addr=0x005, wdata=0x12345678 -> only upg_gnt fires; mem_we=1 and mem_addr=0x005; cpu_stall stays 1 throughout; CPU and debug get no grants.
- Starvation: upg_done=1, dbg_req held while the CPU issues continuous stores -> the 16th arbitration grants debug (starve_cnt saturated at 15), then the CPU resumes and starve_cnt returns to 0.
- Simultaneous CPU and debug requests with starve_cnt=0 -> CPU wins; debug is granted in the next IDLE cycle (N+2 for a CPU store).
- Reset mid-read: rst asserted in ISSUE of a CPU read -> no cpu_rvalid, mem_en=0 and state IDLE immediately; after release the held cpu_req is re-arbitrated normally.
- Perf counters (ARB_PERF_CNT_EN): 3 CPU stores and 2 debug reads -> perf_sel=0 reads 3 and perf_sel=2 reads 2.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared encodings for the data-memory port arbiter: FSM states, access owners,
// performance-counter select codes and a saturating increment helper.
package dmem_arb_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ISSUE  = 2'd1;
  localparam logic [1:0] ST_RDWAIT = 2'd2;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_CPU  = 2'd1;
  localparam logic [1:0] OWN_UPG  = 2'd2;
  localparam logic [1:0] OWN_DBG  = 2'd3;

  localparam logic [1:0] PERF_SEL_CPU_GNT = 2'd0;
  localparam logic [1:0] PERF_SEL_UPG_GNT = 2'd1;
  localparam logic [1:0] PERF_SEL_DBG_GNT = 2'd2;
  localparam logic [1:0] PERF_SEL_STALL   = 2'd3;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    if (v == 32'hFFFF_FFFF) begin
      return v;
    end else begin
      return v + 32'd1;
    end
  endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Winner selection for the data-memory port: upload-exclusive mode, CPU-over-debug
// priority and the debug starvation override, plus the starvation counter.
module dmem_arb_pick
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_idle,
  input  logic       i_upg_done,
  input  logic       i_cpu_req,
  input  logic       i_upg_req,
  input  logic       i_dbg_req,
  output logic [1:0] o_win
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] r_starve_cnt;
  logic          w_starved;

  assign w_starved = (r_starve_cnt == CW'(STARVE_LIMIT));

  // Winner of the current IDLE cycle; OWN_NONE outside IDLE or with no eligible request
  always_comb begin
    o_win = OWN_NONE;
    if (!i_idle) begin
      o_win = OWN_NONE;
    end else if (!i_upg_done) begin
      if (i_upg_req) begin
        o_win = OWN_UPG;
      end else begin
        o_win = OWN_NONE;
      end
    end else if (i_dbg_req && w_starved) begin
      o_win = OWN_DBG;
    end else if (i_cpu_req) begin
      o_win = OWN_CPU;
    end else if (i_dbg_req) begin
      o_win = OWN_DBG;
    end else begin
      o_win = OWN_NONE;
    end
  end

  // Counts arbitrations debug lost to the CPU; saturates so the override sticks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (!i_dbg_req || (o_win == OWN_DBG)) begin
      r_starve_cnt <= '0;
    end else if ((o_win == OWN_CPU) && !w_starved) begin
      r_starve_cnt <= r_starve_cnt + CW'(1);
    end else begin
      r_starve_cnt <= r_starve_cnt;
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Single-port BRAM arbiter/sequencer for CPU, UART upload and debug readout.
// Optional feature macro ARB_PERF_CNT_EN adds perf_sel/perf_cnt grant and stall counters.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W       = 14,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 15
) (
`ifdef ARB_PERF_CNT_EN
  input  logic [1:0]        perf_sel,
  output logic [31:0]       perf_cnt,
`endif
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic              cpu_stall,
  input  logic              upg_done,
  input  logic              upg_req,
  input  logic [ADDR_W-1:0] upg_addr,
  input  logic [DATA_W-1:0] upg_wdata,
  output logic              upg_gnt,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic [1:0]        r_state;
  logic [1:0]        r_owner;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_cpu_gnt;
  logic              r_upg_gnt;
  logic              r_dbg_gnt;
  logic              r_cpu_rvalid;
  logic              r_dbg_rvalid;
  logic [DATA_W-1:0] r_rdata;

  logic [1:0]        w_win;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_cpu_done;

  dmem_arb_pick #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_pick (
    .clk       (clk),
    .rst       (rst),
    .i_idle    (r_state == ST_IDLE),
    .i_upg_done(upg_done),
    .i_cpu_req (cpu_req),
    .i_upg_req (upg_req),
    .i_dbg_req (dbg_req),
    .o_win     (w_win)
  );

  // Access parameters of the winner; reads leave the write-data bus untouched
  always_comb begin
    w_sel_we    = 1'b0;
    w_sel_addr  = r_mem_addr;
    w_sel_wdata = r_mem_wdata;
    case (w_win)
      OWN_CPU: begin
        w_sel_we   = cpu_we;
        w_sel_addr = cpu_addr;
        if (cpu_we) begin
          w_sel_wdata = cpu_wdata;
        end else begin
          w_sel_wdata = r_mem_wdata;
        end
      end
      OWN_UPG: begin
        w_sel_we    = 1'b1;
        w_sel_addr  = upg_addr;
        w_sel_wdata = upg_wdata;
      end
      OWN_DBG: begin
        w_sel_we   = 1'b0;
        w_sel_addr = dbg_addr;
      end
      default: begin
        w_sel_we = 1'b0;
      end
    endcase
  end

  // IDLE -> ISSUE -> (RDWAIT) -> IDLE sequencer with registered BRAM controls and pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_owner      <= OWN_NONE;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_cpu_gnt    <= 1'b0;
      r_upg_gnt    <= 1'b0;
      r_dbg_gnt    <= 1'b0;
      r_cpu_rvalid <= 1'b0;
      r_dbg_rvalid <= 1'b0;
      r_rdata      <= '0;
    end else begin
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_cpu_gnt    <= 1'b0;
      r_upg_gnt    <= 1'b0;
      r_dbg_gnt    <= 1'b0;
      r_cpu_rvalid <= 1'b0;
      r_dbg_rvalid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_win != OWN_NONE) begin
            r_state     <= ST_ISSUE;
            r_owner     <= w_win;
            r_mem_en    <= 1'b1;
            r_mem_we    <= w_sel_we;
            r_mem_addr  <= w_sel_addr;
            r_mem_wdata <= w_sel_wdata;
            r_cpu_gnt   <= (w_win == OWN_CPU);
            r_upg_gnt   <= (w_win == OWN_UPG);
            r_dbg_gnt   <= (w_win == OWN_DBG);
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          if (r_mem_we) begin
            r_state <= ST_IDLE;
            r_owner <= OWN_NONE;
          end else begin
            r_state      <= ST_RDWAIT;
            r_cpu_rvalid <= (r_owner == OWN_CPU);
            r_dbg_rvalid <= (r_owner == OWN_DBG);
          end
        end
        ST_RDWAIT: begin
          r_state <= ST_IDLE;
          r_owner <= OWN_NONE;
          r_rdata <= mem_rdata;
        end
        default: begin
          r_state <= ST_IDLE;
          r_owner <= OWN_NONE;
        end
      endcase
    end
  end

  // BRAM data is presented straight through during RDWAIT and held afterwards
  assign rdata      = (r_state == ST_RDWAIT) ? mem_rdata : r_rdata;
  assign mem_en     = r_mem_en;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign cpu_gnt    = r_cpu_gnt;
  assign upg_gnt    = r_upg_gnt;
  assign dbg_gnt    = r_dbg_gnt;
  assign cpu_rvalid = r_cpu_rvalid;
  assign dbg_rvalid = r_dbg_rvalid;

  assign w_cpu_done = (r_cpu_gnt & cpu_we) | r_cpu_rvalid;
  assign cpu_stall  = ~upg_done | (cpu_req & ~w_cpu_done);

`ifdef ARB_PERF_CNT_EN
  logic [31:0] r_perf_cpu;
  logic [31:0] r_perf_upg;
  logic [31:0] r_perf_dbg;
  logic [31:0] r_perf_stall;

  // Saturating event counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_cpu   <= 32'd0;
      r_perf_upg   <= 32'd0;
      r_perf_dbg   <= 32'd0;
      r_perf_stall <= 32'd0;
    end else begin
      r_perf_cpu   <= r_cpu_gnt ? sat_inc32(r_perf_cpu)   : r_perf_cpu;
      r_perf_upg   <= r_upg_gnt ? sat_inc32(r_perf_upg)   : r_perf_upg;
      r_perf_dbg   <= r_dbg_gnt ? sat_inc32(r_perf_dbg)   : r_perf_dbg;
      r_perf_stall <= cpu_stall ? sat_inc32(r_perf_stall) : r_perf_stall;
    end
  end

  // Counter readout mux
  always_comb begin
    perf_cnt = 32'd0;
    case (perf_sel)
      PERF_SEL_CPU_GNT: perf_cnt = r_perf_cpu;
      PERF_SEL_UPG_GNT: perf_cnt = r_perf_upg;
      PERF_SEL_DBG_GNT: perf_cnt = r_perf_dbg;
      PERF_SEL_STALL:   perf_cnt = r_perf_stall;
      default:          perf_cnt = 32'd0;
    endcase
  end
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed self-checking bench for dmem_port_arbiter with a 1-cycle-latency BRAM model.
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [13:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_gnt, cpu_rvalid, cpu_stall;
  logic        upg_done, upg_req;
  logic [13:0] upg_addr;
  logic [31:0] upg_wdata;
  logic        upg_gnt;
  logic        dbg_req;
  logic [13:0] dbg_addr;
  logic        dbg_gnt, dbg_rvalid;
  logic [31:0] rdata;
  logic        mem_en, mem_we;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'd0;
`ifdef ARB_PERF_CNT_EN
  logic [1:0]  perf_sel = 2'd0;
  logic [31:0] perf_cnt;
`endif

  logic        tb_load;
  logic [31:0] bram [0:16383];
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter dut (
`ifdef ARB_PERF_CNT_EN
    .perf_sel  (perf_sel),
    .perf_cnt  (perf_cnt),
`endif
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_gnt   (cpu_gnt),
    .cpu_rvalid(cpu_rvalid),
    .cpu_stall (cpu_stall),
    .upg_done  (upg_done),
    .upg_req   (upg_req),
    .upg_addr  (upg_addr),
    .upg_wdata (upg_wdata),
    .upg_gnt   (upg_gnt),
    .dbg_req   (dbg_req),
    .dbg_addr  (dbg_addr),
    .dbg_gnt   (dbg_gnt),
    .dbg_rvalid(dbg_rvalid),
    .rdata     (rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // BRAM model with one cycle of read latency
  always @(posedge clk) begin
    if (tb_load) begin
      bram[14'h010] <= 32'hDEAD_BEEF;
    end else if (mem_en) begin
      if (mem_we) bram[mem_addr] <= mem_wdata;
      else        mem_rdata <= bram[mem_addr];
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int  n_cpu;
  int  n_dbg;
  logic got_dbg;
  logic any_bad;

  initial begin
    rst = 1'b1; tb_load = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 14'd0; cpu_wdata = 32'd0;
    upg_done = 1'b1; upg_req = 1'b0; upg_addr = 14'd0; upg_wdata = 32'd0;
    dbg_req = 1'b0; dbg_addr = 14'd0;
    repeat (3) tick();
    check_val("rst_mem_en", {31'd0, mem_en}, 32'd0);
    check_val("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check_val("rst_mem_addr", {18'd0, mem_addr}, 32'd0);
    check_val("rst_mem_wdata", mem_wdata, 32'd0);
    check_val("rst_rdata", rdata, 32'd0);
    check_val("rst_pulses", {27'd0, cpu_gnt, upg_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid}, 32'd0);
    tb_load = 1'b0; rst = 1'b0;
    tick();

    // CPU load of 0x010
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h010; #1;
    check_val("ld_stall_n", {31'd0, cpu_stall}, 32'd1);
    tick();
    check_val("ld_gnt", {31'd0, cpu_gnt}, 32'd1);
    check_val("ld_mem_en", {31'd0, mem_en}, 32'd1);
    check_val("ld_mem_we", {31'd0, mem_we}, 32'd0);
    check_val("ld_mem_addr", {18'd0, mem_addr}, 32'h010);
    check_val("ld_stall_n1", {31'd0, cpu_stall}, 32'd1);
    tick();
    check_val("ld_rvalid", {31'd0, cpu_rvalid}, 32'd1);
    check_val("ld_rdata", rdata, 32'hDEAD_BEEF);
    check_val("ld_stall_n2", {31'd0, cpu_stall}, 32'd0);
    check_val("ld_en_off", {31'd0, mem_en}, 32'd0);
    tick();
    cpu_req = 1'b0; #1;
    check_val("ld_rvalid_off", {31'd0, cpu_rvalid}, 32'd0);
    check_val("ld_rdata_hold", rdata, 32'hDEAD_BEEF);
    check_val("ld_addr_hold", {18'd0, mem_addr}, 32'h010);
    tick();

    // Upload exclusivity: all three request, only upload is served
    upg_done = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h020;
    dbg_req = 1'b1; dbg_addr = 14'h030;
    upg_req = 1'b1; upg_addr = 14'h005; upg_wdata = 32'h1234_5678; #1;
    check_val("up_stall_n", {31'd0, cpu_stall}, 32'd1);
    tick();
    check_val("up_gnts", {29'd0, cpu_gnt, upg_gnt, dbg_gnt}, 32'b010);
    check_val("up_mem_we", {31'd0, mem_we}, 32'd1);
    check_val("up_mem_addr", {18'd0, mem_addr}, 32'h005);
    check_val("up_mem_wdata", mem_wdata, 32'h1234_5678);
    tick();
    upg_req = 1'b0;
    any_bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (cpu_gnt || dbg_gnt || upg_gnt || !cpu_stall) any_bad = 1'b1;
      tick();
    end
    check_val("up_exclusive", {31'd0, any_bad}, 32'd0);
    check_val("up_bram", bram[14'h005], 32'h1234_5678);
    cpu_req = 1'b0; dbg_req = 1'b0;
    tick();
    upg_done = 1'b1;
    tick();

    // Simultaneous CPU store and debug read: CPU first, debug next
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h040; cpu_wdata = 32'hAAAA_5555;
    dbg_req = 1'b1; dbg_addr = 14'h010;
    tick();
    check_val("sim_gnts_n1", {30'd0, cpu_gnt, dbg_gnt}, 32'b10);
    check_val("sim_mem_we", {31'd0, mem_we}, 32'd1);
    check_val("sim_st_stall", {31'd0, cpu_stall}, 32'd0);
    tick();
    cpu_req = 1'b0; #1;
    check_val("sim_idle_n2", {30'd0, cpu_gnt, dbg_gnt}, 32'b00);
    tick();
    check_val("sim_gnts_n3", {30'd0, cpu_gnt, dbg_gnt}, 32'b01);
    check_val("sim_dbg_addr", {18'd0, mem_addr}, 32'h010);
    tick();
    dbg_req = 1'b0; #1;
    check_val("sim_dbg_rvalid", {30'd0, cpu_rvalid, dbg_rvalid}, 32'b01);
    check_val("sim_dbg_rdata", rdata, 32'hDEAD_BEEF);
    check_val("sim_bram", bram[14'h040], 32'hAAAA_5555);
    tick();

    // Starvation: continuous CPU stores with debug held
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h050; cpu_wdata = 32'h0000_0001;
    dbg_req = 1'b1; dbg_addr = 14'h040;
    n_cpu = 0; got_dbg = 1'b0;
    for (int i = 0; i < 80 && !got_dbg; i++) begin
      tick();
      if (cpu_gnt) n_cpu++;
      if (dbg_gnt) got_dbg = 1'b1;
    end
    check_val("starve_dbg_won", {31'd0, got_dbg}, 32'd1);
    check_val("starve_cpu_wins", n_cpu, 32'd15);
    tick();
    check_val("starve_dbg_rdata", rdata, 32'hAAAA_5555);
    check_val("starve_dbg_rvalid", {31'd0, dbg_rvalid}, 32'd1);
    tick();
    tick();
    check_val("starve_cpu_resume", {30'd0, cpu_gnt, dbg_gnt}, 32'b10);
    tick();
    cpu_req = 1'b0; dbg_req = 1'b0;
    tick();

    // Reset during ISSUE of a CPU read
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h010;
    tick();
    check_val("rr_gnt", {31'd0, cpu_gnt}, 32'd1);
    rst = 1'b1; #1;
    check_val("rr_en_now", {31'd0, mem_en}, 32'd0);
    check_val("rr_rdata_now", rdata, 32'd0);
    tick();
    check_val("rr_no_rvalid", {31'd0, cpu_rvalid}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check_val("rr_regnt", {31'd0, cpu_gnt}, 32'd1);
    tick();
    check_val("rr_rvalid", {31'd0, cpu_rvalid}, 32'd1);
    check_val("rr_rdata", rdata, 32'hDEAD_BEEF);
    tick();
    cpu_req = 1'b0;
    tick();

`ifdef ARB_PERF_CNT_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h060;
    n_cpu = 0;
    for (int i = 0; i < 30 && n_cpu < 3; i++) begin
      tick();
      if (cpu_gnt) n_cpu++;
      if (n_cpu == 3) cpu_req = 1'b0;
    end
    cpu_req = 1'b0;
    dbg_req = 1'b1; dbg_addr = 14'h010;
    n_dbg = 0;
    for (int i = 0; i < 30 && n_dbg < 2; i++) begin
      tick();
      if (dbg_gnt) n_dbg++;
      if (n_dbg == 2) dbg_req = 1'b0;
    end
    dbg_req = 1'b0;
    repeat (4) tick();
    perf_sel = 2'd0; #1;
    check_val("perf_cpu", perf_cnt, 32'd3);
    perf_sel = 2'd1; #1;
    check_val("perf_upg", perf_cnt, 32'd0);
    perf_sel = 2'd2; #1;
    check_val("perf_dbg", perf_cnt, 32'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
